core_run_ctrl: RTL and testbench

Run controller that sequences one program execution on the single-cycle core. It holds the core in reset, loads the start PC, enables execution, detects completion at PC == DONE_PC, and enforces a cycle-budget timeout. When the core is not running, it also arbitrates the data-memory port between the core and a host loader.

---
 rtl/core_run_if.sv | 34 +++
 rtl/core_run_ctrl.sv | 129 ++++++++++++
 tb/tb_core_run_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/core_run_if.sv
// Run-controller handshake bundle: run requests, core control, host memory-port
// arbitration and status.
interface core_run_if #(
   parameter int PC_W  = 12,
   parameter int CNT_W = 16
);
   logic              start;
   logic [PC_W-1:0]   start_pc;
   logic              abort;
   logic              ack;
   logic [PC_W-1:0]   pc_in;
   logic              host_req;
   logic              core_rst;
   logic              core_en;
   logic              pc_load;
   logic [PC_W-1:0]   pc_load_val;
   logic              host_gnt;
   logic              busy;
   logic              done;
   logic              timed_out;
   logic [CNT_W-1:0]  cycle_count;

   modport slave (
      input  start, start_pc, abort, ack, pc_in, host_req,
      output core_rst, core_en, pc_load, pc_load_val, host_gnt,
             busy, done, timed_out, cycle_count
   );

   modport master (
      output start, start_pc, abort, ack, pc_in, host_req,
      input  core_rst, core_en, pc_load, pc_load_val, host_gnt,
             busy, done, timed_out, cycle_count
   );
endinterface

// File: rtl/core_run_ctrl.sv
// Sequences one program run on the core: reset hold, PC load, execute, stop on
// DONE_PC or cycle-budget timeout; arbitrates the data-memory port to the host.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | core held in reset, waiting for start
//   ST_CLEAR | core_rst held RST_CYCLES cycles, PC loaded on the last one
//   ST_RUN   | core enabled, counting cycles, watching for exit conditions
//   ST_DONE  | program reached DONE_PC, core frozen, waiting for ack
//   ST_FAULT | cycle budget exhausted, core frozen, waiting for ack
module core_run_ctrl #(
   parameter int PC_W       = 12,
   parameter int DONE_PC    = 2000,
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 50000,
   parameter int RST_CYCLES = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   core_run_if.slave bus
);

   localparam int                CLR_W    = $clog2(RST_CYCLES + 1);
   localparam logic [CLR_W-1:0]  CLR_INIT = CLR_W'(RST_CYCLES);
   localparam logic [CLR_W-1:0]  CLR_ONE  = CLR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [PC_W-1:0]   PC_DONE  = PC_W'(DONE_PC);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DONE,
      ST_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  pc_val_q, pc_val_d;
   logic             core_rst_q, core_rst_d;
   logic             core_en_q, core_en_d;
   logic             pc_load_q, pc_load_d;
   logic             host_gnt_q, host_gnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timed_out_q, timed_out_d;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      cnt_d     = cnt_q;
      pc_val_d  = pc_val_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start && !host_gnt_q) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = CLR_INIT;
               cnt_d     = '0;
               pc_val_d  = bus.start_pc;
            end
         end
         ST_CLEAR: begin
            if (clr_cnt_q == CLR_ONE) state_d = ST_RUN;
            else                      clr_cnt_d = clr_cnt_q - CLR_ONE;
         end
         ST_RUN: begin
            // Priority: abort, completion, timeout; the count freezes on any exit.
            if (bus.abort)                 state_d = ST_IDLE;
            else if (bus.pc_in == PC_DONE) state_d = ST_DONE;
            else if (cnt_q == CNT_LAST)    state_d = ST_FAULT;
            else if (cnt_q != '1)          cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_DONE, ST_FAULT: begin
            if (bus.ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      core_rst_d  = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
      core_en_d   = (state_d == ST_RUN);
      pc_load_d   = (state_d == ST_CLEAR) && (clr_cnt_d == CLR_ONE);
      busy_d      = (state_d == ST_CLEAR) || (state_d == ST_RUN);
      done_d      = (state_d == ST_DONE);
      timed_out_d = (state_d == ST_FAULT);
      // A request raised during a run stays pending until the run has exited.
      host_gnt_d  = bus.host_req && !busy_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         clr_cnt_q   <= '0;
         cnt_q       <= '0;
         pc_val_q    <= '0;
         core_rst_q  <= 1'b1;
         core_en_q   <= 1'b0;
         pc_load_q   <= 1'b0;
         host_gnt_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         cnt_q       <= cnt_d;
         pc_val_q    <= pc_val_d;
         core_rst_q  <= core_rst_d;
         core_en_q   <= core_en_d;
         pc_load_q   <= pc_load_d;
         host_gnt_q  <= host_gnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timed_out_q <= timed_out_d;
      end
   end

   assign bus.core_rst    = core_rst_q;
   assign bus.core_en     = core_en_q;
   assign bus.pc_load     = pc_load_q;
   assign bus.pc_load_val = pc_val_q;
   assign bus.host_gnt    = host_gnt_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timed_out   = timed_out_q;
   assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a 100-cycle budget and 2-cycle reset hold.
module tb_core_run_ctrl;

   localparam int PC_W  = 12;
   localparam int CNT_W = 16;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   core_run_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   core_run_ctrl #(
      .PC_W       (PC_W),
      .DONE_PC    (2000),
      .CNT_W      (CNT_W),
      .MAX_CYCLES (100),
      .RST_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench in the first RUN cycle (cycle_count == 0).
   task automatic launch(input logic [PC_W-1:0] pc);
      bus.start    = 1'b1;
      bus.start_pc = pc;
      step();
      bus.start = 1'b0;
      step(2);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rst"},  {31'd0, bus.core_rst}, 32'd1);
      chk({tag, "_en"},   {31'd0, bus.core_en}, 32'd0);
      chk({tag, "_ld"},   {31'd0, bus.pc_load}, 32'd0);
      chk({tag, "_ldv"},  {20'd0, bus.pc_load_val}, 32'd0);
      chk({tag, "_gnt"},  {31'd0, bus.host_gnt}, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_to"},   {31'd0, bus.timed_out}, 32'd0);
      chk({tag, "_cnt"},  {16'd0, bus.cycle_count}, 32'd0);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.start_pc = '0;
      bus.abort    = 1'b0;
      bus.ack      = 1'b0;
      bus.pc_in    = '0;
      bus.host_req = 1'b0;
      #23;
      chk_reset_vals("por");
      rst_n = 1'b1;
      step(2);
      chk("idle_rst", {31'd0, bus.core_rst}, 32'd1);

      // Clear sequence and PC load
      bus.start    = 1'b1;
      bus.start_pc = 12'h010;
      step();
      bus.start = 1'b0;
      chk("clr1_rst",  {31'd0, bus.core_rst}, 32'd1);
      chk("clr1_busy", {31'd0, bus.busy}, 32'd1);
      chk("clr1_ld",   {31'd0, bus.pc_load}, 32'd0);
      step();
      chk("clr2_rst",  {31'd0, bus.core_rst}, 32'd1);
      chk("clr2_ld",   {31'd0, bus.pc_load}, 32'd1);
      chk("clr2_ldv",  {20'd0, bus.pc_load_val}, 32'h010);
      chk("clr2_en",   {31'd0, bus.core_en}, 32'd0);
      step();
      chk("run1_en",   {31'd0, bus.core_en}, 32'd1);
      chk("run1_rst",  {31'd0, bus.core_rst}, 32'd0);
      chk("run1_ld",   {31'd0, bus.pc_load}, 32'd0);
      chk("run1_busy", {31'd0, bus.busy}, 32'd1);
      chk("run1_cnt",  {16'd0, bus.cycle_count}, 32'd0);

      // Completion after 37 RUN cycles
      bus.pc_in = 12'h010;
      step(37);
      chk("run38_cnt", {16'd0, bus.cycle_count}, 32'd37);
      bus.pc_in = 12'd2000;
      step();
      chk("done_done", {31'd0, bus.done}, 32'd1);
      chk("done_en",   {31'd0, bus.core_en}, 32'd0);
      chk("done_rst",  {31'd0, bus.core_rst}, 32'd0);
      chk("done_cnt",  {16'd0, bus.cycle_count}, 32'd37);
      chk("done_busy", {31'd0, bus.busy}, 32'd0);
      bus.start = 1'b1;
      step();
      chk("done_start_ign", {31'd0, bus.done}, 32'd1);
      bus.ack = 1'b1;
      step();
      bus.ack   = 1'b0;
      bus.start = 1'b0;
      chk("ack_done", {31'd0, bus.done}, 32'd0);
      chk("ack_rst",  {31'd0, bus.core_rst}, 32'd1);
      step();
      chk("ack_start_drop", {31'd0, bus.busy}, 32'd0);
      bus.pc_in = '0;

      // Timeout at the cycle budget
      launch(12'h020);
      step(99);
      chk("to_run100_cnt", {16'd0, bus.cycle_count}, 32'd99);
      chk("to_run100_en",  {31'd0, bus.core_en}, 32'd1);
      step();
      chk("to_fault", {31'd0, bus.timed_out}, 32'd1);
      chk("to_done",  {31'd0, bus.done}, 32'd0);
      chk("to_cnt",   {16'd0, bus.cycle_count}, 32'd99);
      chk("to_en",    {31'd0, bus.core_en}, 32'd0);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("to_ack", {31'd0, bus.timed_out}, 32'd0);

      // Completion coinciding with the budget limit
      launch(12'h030);
      step(99);
      bus.pc_in = 12'd2000;
      step();
      bus.pc_in = '0;
      chk("coin_done", {31'd0, bus.done}, 32'd1);
      chk("coin_to",   {31'd0, bus.timed_out}, 32'd0);
      chk("coin_cnt",  {16'd0, bus.cycle_count}, 32'd99);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;

      // Host request held off during RUN
      launch(12'h040);
      bus.host_req = 1'b1;
      step(3);
      chk("host_run_gnt", {31'd0, bus.host_gnt}, 32'd0);
      bus.pc_in = 12'd2000;
      step();
      bus.pc_in = '0;
      chk("host_exit_gnt",  {31'd0, bus.host_gnt}, 32'd1);
      chk("host_exit_done", {31'd0, bus.done}, 32'd1);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("host_idle_gnt", {31'd0, bus.host_gnt}, 32'd1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("host_start_busy", {31'd0, bus.busy}, 32'd0);
      chk("host_start_rst",  {31'd0, bus.core_rst}, 32'd1);
      bus.host_req = 1'b0;
      step();
      chk("host_release", {31'd0, bus.host_gnt}, 32'd0);

      // Abort wins over completion
      launch(12'h050);
      step(4);
      bus.abort = 1'b1;
      bus.pc_in = 12'd2000;
      step();
      bus.abort = 1'b0;
      bus.pc_in = '0;
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_rst",  {31'd0, bus.core_rst}, 32'd1);
      chk("abort_cnt",  {16'd0, bus.cycle_count}, 32'd4);
      step();
      chk("abort_done2", {31'd0, bus.done}, 32'd0);

      // Asynchronous reset mid-RUN
      launch(12'h060);
      step(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrun");
      #3;
      rst_n = 1'b1;
      step(2);
      chk("post_rst_rst",  {31'd0, bus.core_rst}, 32'd1);
      chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("post_rst_done", {31'd0, bus.done}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
